vliw_fetch_stage: RTL and testbench
===================================

Name: vliw_fetch_stage

Overview:
- Instruction fetch stage directly upstream of the IF/ID pipeline register. It holds the PC and fetches 32-bit two-slot bundles: bits [31:16] are the MEM slot and bits [15:0] are the ALU slot.
- Requests go to instruction memory over a req/ack handshake, with at most one request outstanding. Returned bundles are buffered with their PC+4 in a small FIFO.
- The FIFO head is presented to IF/ID. The stage handles branch/jump redirects from EX and produces a NOP bubble when it has nothing valid to present.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, bundle buffer entries; legal values 2 or 4 (power of two).
- NOP_BUNDLE, 32'h0000_0000, bundle presented when the FIFO is empty.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high.
- imem_ack  in  1  response valid, at least 1 cycle after imem_req rises.
- imem_rdata  in  32  returned bundle, sampled when imem_ack is high.
- if_id_write  in  1  IF/ID regWrite; high means IF/ID consumes this cycle.
- redirect  in  1  taken branch/jump resolved in EX (pcSrc).
- redirect_target  in  32  new PC; bits [1:0] are ignored (treated as 0).
- if_instr2Word  out  32  head bundle, or NOP_BUNDLE when empty.
- if_pc_plus4  out  32  PC+4 of the head bundle; 0 when empty.
- if_valid  out  1  FIFO not empty.
- if_flush  out  1  drives IF_flush of IF/ID; equals redirect (combinational).

Behaviour:
- Reset values:
  - pc = RESET_PC; FIFO empty.
  - imem_req = 0; FSM = IDLE; imem_addr = RESET_PC.
  - if_valid = 0; if_instr2Word = NOP_BUNDLE; if_pc_plus4 = 0; if_flush = redirect.
- Ports imem_addr, if_instr2Word, if_pc_plus4 and if_valid are driven from registers/FIFO storage only.
- FSM has three states:
  - IDLE: no request outstanding. If space > 0, where space = FIFO_DEPTH − count, raise imem_req with imem_addr = pc and go to WAIT.
  - WAIT: request outstanding. On imem_ack, push {imem_rdata, imem_addr+4} and set pc = imem_addr+4.
    - If space remains after the push and the pop, immediately issue the next request at the new pc and stay in WAIT (back-to-back fetch, one bundle per ack). Otherwise go to IDLE.
  - DROP: a redirect arrived while a request was outstanding. imem_req stays high at the stale address until imem_ack. The returned data is discarded (no push). Then go to IDLE, or issue a request at the new pc and go to WAIT.
- Space accounting: an outstanding request reserves one slot, so the FIFO can never overflow.
- Pop: when if_id_write && if_valid && !redirect, the head advances.
  - if_id_write while empty pops nothing; IF/ID latches NOP_BUNDLE, which is a legal bubble.
- Push and pop in the same cycle: count is unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
- Redirect (single cycle, highest priority):
  - The FIFO is cleared at the clock edge and pc = {redirect_target[31:2], 2'b00}. No pop occurs.
  - In IDLE, the request at the target is issued next cycle.
  - In WAIT, the FSM goes to DROP. If imem_ack arrives in the same cycle as redirect, that data is discarded and the FSM goes to IDLE.
  - In DROP, the FSM stays in DROP and only pc is updated.
- Stall: while if_id_write = 0 the head is held steady. Fetch continues until the FIFO is full, then imem_req stays low.
- Reset mid-request: state clears asynchronously. A late imem_ack arriving in IDLE is ignored; the memory tolerates an abandoned request.
- Arithmetic: 32-bit PC with wrap-around, so 32'hFFFF_FFFC + 4 = 0. There is no misalignment trap.
- Latency: redirect at cycle N gives imem_req at the target in cycle N+1. With a 1-cycle ack, if_valid rises in cycle N+3.

Decomposition:
- Shared package holds:
  - BUNDLE_W = 32, SLOT_W = 16, NOP_BUNDLE.
  - Fetch FSM state encoding: IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2.
  - Slot field positions: MEM slot [31:16], ALU slot [15:0].
- One sub-module, fetch_bundle_fifo: a FIFO_DEPTH × 64-bit synchronous FIFO with push, pop, clear, count, empty and full. Its reset is asynchronous.

Test Plan:
- Reset then run with a 1-cycle ack memory and if_id_write = 1: addresses 0x0, 0x4, 0x8 are issued in order, and if_pc_plus4 shows 0x4, 0x8, 0xC.
- Hold if_id_write = 0 for 10 cycles: exactly FIFO_DEPTH bundles are buffered, imem_req goes low, and the head stays 0x0/0x4 with no overflow.
- redirect = 1 with target 0x103 while in WAIT: if_flush = 1 that cycle, the FIFO empties, and the stale ack data is dropped. The next imem_addr is 0x100 and the first if_pc_plus4 is 0x104.
- redirect in the same cycle as imem_ack with rdata 0xDEADBEEF: 0xDEADBEEF never appears on if_instr2Word, and the FSM goes to IDLE.
- Redirect to 0xFFFF_FFFC: the fetch after it is at 0x0000_0000, and if_pc_plus4 is 0x0 then 0x4.
- Assert reset while in WAIT with a 3-cycle ack: outputs return to reset values immediately, the late ack is ignored, and the first post-reset imem_addr is RESET_PC.

Source files
------------

// File: rtl/vliw_fetch_stage_pkg.sv
// Shared definitions for the VLIW instruction fetch stage.
// Provides bundle and slot widths, the default NOP bundle, the fetch FSM state
// encoding and a word-alignment helper used on redirect targets.
package vliw_fetch_stage_pkg;

  localparam int unsigned BUNDLE_W = 32;
  localparam int unsigned SLOT_W   = 16;
  localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = 32'h0000_0000;

  // Slot field positions inside a bundle.
  localparam int unsigned MEM_SLOT_MSB = 31;
  localparam int unsigned MEM_SLOT_LSB = 16;
  localparam int unsigned ALU_SLOT_MSB = 15;
  localparam int unsigned ALU_SLOT_LSB = 0;

  // One FIFO entry carries {bundle, pc_plus4}.
  localparam int unsigned FIFO_ENTRY_W = 2 * BUNDLE_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_bundle_fifo.sv
// Small synchronous FIFO buffering fetched bundles with their PC+4.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write an entry (ignored when full)
//   pop               advance the head (ignored when empty)
//   clear             synchronous flush; wins over push/pop
//   head_data         entry at the head (undefined when empty)
//   count/empty/full  occupancy status
module fetch_bundle_fifo
  import vliw_fetch_stage_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = FIFO_ENTRY_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  input  logic                        clear,
  output logic [DATA_W-1:0]           head_data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vliw_fetch_stage.sv
// VLIW instruction fetch stage feeding the IF/ID pipeline register.
// Holds the PC, fetches 32-bit two-slot bundles over a single-outstanding
// req/ack interface, buffers {bundle, pc+4} in a small FIFO and presents the
// head to IF/ID. EX redirects flush the buffer and retarget the PC; data for a
// request that was in flight at redirect time is discarded.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata    instruction memory handshake
//   if_id_write                IF/ID consumes the presented bundle this cycle
//   redirect, redirect_target  taken branch/jump from EX
//   if_instr2Word, if_pc_plus4 head bundle and its PC+4 (NOP / 0 when empty)
//   if_valid                   buffer not empty
//   if_flush                   IF_flush to IF/ID, mirrors redirect
module vliw_fetch_stage
  import vliw_fetch_stage_pkg::*;
#(
  parameter logic [31:0]          RESET_PC   = 32'h0000_0000,
  parameter int unsigned          FIFO_DEPTH = 2,
  parameter logic [BUNDLE_W-1:0]  NOP_BUNDLE = vliw_fetch_stage_pkg::NOP_BUNDLE
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [BUNDLE_W-1:0] imem_rdata,
  input  logic                if_id_write,
  input  logic                redirect,
  input  logic [31:0]         redirect_target,
  output logic [BUNDLE_W-1:0] if_instr2Word,
  output logic [31:0]         if_pc_plus4,
  output logic                if_valid,
  output logic                if_flush
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CA_W  = CNT_W + 1;

  fetch_state_e            state;
  logic [31:0]             pc;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [FIFO_ENTRY_W-1:0] fifo_head;
  logic                    push;
  logic                    pop;
  logic [31:0]             target_aligned;
  logic [31:0]             next_pc;
  logic [CA_W-1:0]         count_after;
  logic                    space_after;

  assign if_flush       = redirect;
  assign target_aligned = align_word(redirect_target);
  assign next_pc        = imem_addr + 32'd4;

  // Redirect has priority: it suppresses both the pop and any push.
  assign pop  = if_id_write && !fifo_empty && !redirect;
  assign push = (state == StWait) && imem_ack && !redirect;

  // Occupancy after this cycle's push/pop; the next request reserves a slot,
  // so it may only be issued while this stays below depth.
  assign count_after = CA_W'(fifo_count) + CA_W'(push) - CA_W'(pop);
  assign space_after = (count_after < CA_W'(FIFO_DEPTH));

  fetch_bundle_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (FIFO_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rdata, next_pc}),
    .pop       (pop),
    .clear     (redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      unique case (state)
        StIdle: begin
          if (redirect) begin
            // Buffer is cleared this edge, so there is always room.
            pc        <= target_aligned;
            imem_addr <= target_aligned;
            imem_req  <= 1'b1;
            state     <= StWait;
          end else if (!fifo_full) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            pc <= target_aligned;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= StIdle;
            end else begin
              state <= StDrop;
            end
          end else if (imem_ack) begin
            pc <= next_pc;
            if (space_after) begin
              imem_addr <= next_pc;
            end else begin
              imem_req <= 1'b0;
              state    <= StIdle;
            end
          end
        end
        StDrop: begin
          if (redirect) begin
            pc <= target_aligned;
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= StIdle;
            end
          end else if (imem_ack) begin
            if (space_after) begin
              imem_addr <= pc;
              state     <= StWait;
            end else begin
              imem_req <= 1'b0;
              state    <= StIdle;
            end
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= StIdle;
        end
      endcase
    end
  end

  assign if_valid      = !fifo_empty;
  assign if_instr2Word = fifo_empty ? NOP_BUNDLE : fifo_head[FIFO_ENTRY_W-1:32];
  assign if_pc_plus4   = fifo_empty ? 32'd0 : fifo_head[31:0];

endmodule

// File: tb/tb_vliw_fetch_stage.sv
// Directed testbench for vliw_fetch_stage with a latency-programmable memory.
module tb_vliw_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_id_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] if_instr2Word;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        if_flush;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model controls (written only by the test sequence).
  int mem_lat      = 1;
  bit mem_override = 1'b0;
  int late_req     = 0;

  always #5 clk = ~clk;

  vliw_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .NOP_BUNDLE (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_id_write     (if_id_write),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_instr2Word   (if_instr2Word),
    .if_pc_plus4     (if_pc_plus4),
    .if_valid        (if_valid),
    .if_flush        (if_flush)
  );

  function automatic logic [31:0] bundle_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // Memory: acks a request mem_lat cycles after it is first seen.
  // Changes on the falling edge so the DUT samples stable values.
  initial begin
    int cnt;
    int late_done;
    cnt = 0;
    late_done = 0;
    forever begin
      @(negedge clk);
      if (late_req != late_done) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cnt        = 0;
        late_done++;
      end else if (reset) begin
        imem_ack = 1'b0;
        cnt      = 0;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        cnt      = imem_req ? 1 : 0;
      end else if (imem_req) begin
        cnt++;
        if (cnt > mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_override ? 32'hDEAD_BEEF : bundle_of(imem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    if_id_write     = 1'b0;
    mem_override    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr);
    else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid);
    else n_pass++;
    n_checks++; if (if_instr2Word !== NOP)
      $display("FAIL reset_instr: got %h want %h", if_instr2Word, NOP);
    else n_pass++;
    n_checks++; if (if_pc_plus4 !== 32'h0) $display("FAIL reset_pc4: got %h want 0", if_pc_plus4);
    else n_pass++;
    n_checks++; if (if_flush !== 1'b0) $display("FAIL reset_flush0: got %b want 0", if_flush);
    else n_pass++;
    redirect = 1'b1;
    #1;
    n_checks++; if (if_flush !== 1'b1) $display("FAIL reset_flush1: got %b want 1", if_flush);
    else n_pass++;
    redirect = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] addrs  [3];
    logic [31:0] pc4s   [3];
    logic [31:0] instrs [3];
    int na;
    int np;
    na = 0;
    np = 0;
    do_reset();
    mem_lat     = 1;
    if_id_write = 1'b1;
    for (int i = 0; i < 40 && (na < 3 || np < 3); i++) begin
      tick();
      if (imem_req && imem_ack && na < 3) begin addrs[na] = imem_addr; na++; end
      if (if_valid && np < 3) begin pc4s[np] = if_pc_plus4; instrs[np] = if_instr2Word; np++; end
    end
    n_checks++; if (na != 3 || np != 3)
      $display("FAIL seq_timeout: got %0d acks %0d pops, want 3 and 3", na, np);
    else n_pass++;
    for (int i = 0; i < na; i++) begin
      n_checks++; if (addrs[i] !== 32'(4 * i))
        $display("FAIL seq_addr%0d: got %h want %h", i, addrs[i], 32'(4 * i));
      else n_pass++;
    end
    for (int i = 0; i < np; i++) begin
      n_checks++; if (pc4s[i] !== 32'(4 * i + 4))
        $display("FAIL seq_pc4_%0d: got %h want %h", i, pc4s[i], 32'(4 * i + 4));
      else n_pass++;
      n_checks++; if (instrs[i] !== bundle_of(32'(4 * i)))
        $display("FAIL seq_instr%0d: got %h want %h", i, instrs[i], bundle_of(32'(4 * i)));
      else n_pass++;
    end
    if_id_write = 1'b0;
  endtask

  task automatic test_stall();
    int acks;
    int moved;
    acks  = 0;
    moved = 0;
    do_reset();
    mem_lat     = 1;
    if_id_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req && imem_ack) acks++;
      if (if_valid && if_pc_plus4 !== 32'h4) moved++;
    end
    n_checks++; if (acks != DEPTH) $display("FAIL stall_acks: got %0d want %0d", acks, DEPTH);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++; if (moved != 0) $display("FAIL stall_head_moved: got %0d want 0", moved);
    else n_pass++;
    n_checks++; if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h4)
      $display("FAIL stall_head: got valid %b pc4 %h want 1 00000004", if_valid, if_pc_plus4);
    else n_pass++;
    n_checks++; if (if_instr2Word !== bundle_of(32'h0))
      $display("FAIL stall_instr: got %h want %h", if_instr2Word, bundle_of(32'h0));
    else n_pass++;
    if_id_write = 1'b1;
    tick();
    if_id_write = 1'b0;
    n_checks++; if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h8)
      $display("FAIL stall_second: got valid %b pc4 %h want 1 00000008", if_valid, if_pc_plus4);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit          found;
    bit          seen_stale;
    bit          got_new;
    logic [31:0] new_addr;
    found      = 1'b0;
    seen_stale = 1'b0;
    got_new    = 1'b0;
    new_addr   = 32'hFFFF_FFFF;
    do_reset();
    mem_lat     = 3;
    if_id_write = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found || imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL rdw_setup: got found %b req %b addr %h want 1 1 00000004",
               found, imem_req, imem_addr);
    else n_pass++;
    redirect        = 1'b1;
    redirect_target = 32'h0000_0103;
    #1;
    n_checks++; if (if_flush !== 1'b1) $display("FAIL rdw_flush: got %b want 1", if_flush);
    else n_pass++;
    tick();
    redirect = 1'b0;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rdw_cleared: got %b want 0", if_valid);
    else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL rdw_stale_hold: got req %b addr %h want 1 00000004", imem_req, imem_addr);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_req && imem_ack && imem_addr == 32'h4) seen_stale = 1'b1;
      else if (seen_stale && imem_req && !got_new) begin
        new_addr = imem_addr;
        got_new  = 1'b1;
      end
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (seen_stale !== 1'b1) $display("FAIL rdw_stale_ack: got %b want 1", seen_stale);
    else n_pass++;
    n_checks++; if (new_addr !== 32'h100)
      $display("FAIL rdw_new_addr: got %h want 00000100", new_addr);
    else n_pass++;
    n_checks++; if (!found || if_pc_plus4 !== 32'h104)
      $display("FAIL rdw_pc4: got valid %b pc4 %h want 1 00000104", found, if_pc_plus4);
    else n_pass++;
    n_checks++; if (if_instr2Word !== bundle_of(32'h100))
      $display("FAIL rdw_instr: got %h want %h", if_instr2Word, bundle_of(32'h100));
    else n_pass++;
  endtask

  task automatic test_redirect_ack();
    bit          found;
    int          bad;
    bit          got_addr;
    bit          got_pc4;
    logic [31:0] first_addr;
    logic [31:0] first_pc4;
    found      = 1'b0;
    bad        = 0;
    got_addr   = 1'b0;
    got_pc4    = 1'b0;
    first_addr = 32'hFFFF_FFFF;
    first_pc4  = 32'hFFFF_FFFF;
    do_reset();
    mem_lat      = 1;
    if_id_write  = 1'b1;
    mem_override = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (imem_ack) found = 1'b1;
    end
    redirect        = 1'b1;
    redirect_target = 32'h0000_0200;
    #1;
    n_checks++; if (!found || if_flush !== 1'b1)
      $display("FAIL rda_flush: got ack %b flush %b want 1 1", found, if_flush);
    else n_pass++;
    mem_override = 1'b0;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rda_idle_req: got %b want 0", imem_req);
    else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rda_valid: got %b want 0", if_valid);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_valid && if_instr2Word == 32'hDEAD_BEEF) bad++;
      if (imem_req && !got_addr) begin first_addr = imem_addr; got_addr = 1'b1; end
      if (if_valid && !got_pc4) begin first_pc4 = if_pc_plus4; got_pc4 = 1'b1; end
    end
    n_checks++; if (bad != 0) $display("FAIL rda_deadbeef_seen: got %0d want 0", bad);
    else n_pass++;
    n_checks++; if (first_addr !== 32'h200)
      $display("FAIL rda_addr: got %h want 00000200", first_addr);
    else n_pass++;
    n_checks++; if (first_pc4 !== 32'h204) $display("FAIL rda_pc4: got %h want 00000204", first_pc4);
    else n_pass++;
    if_id_write = 1'b0;
  endtask

  task automatic test_wrap();
    bit found;
    found = 1'b0;
    do_reset();
    mem_lat         = 1;
    if_id_write     = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req: got req %b addr %h want 1 fffffffc", imem_req, imem_addr);
    else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL wrap_n2_valid: got %b want 0", if_valid);
    else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc_plus4 !== 32'h0)
      $display("FAIL wrap_first: got valid %b pc4 %h want 1 00000000", if_valid, if_pc_plus4);
    else n_pass++;
    n_checks++; if (if_instr2Word !== bundle_of(32'hFFFF_FFFC))
      $display("FAIL wrap_instr: got %h want %h", if_instr2Word, bundle_of(32'hFFFF_FFFC));
    else n_pass++;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found || if_pc_plus4 !== 32'h4 || if_instr2Word !== bundle_of(32'h0))
      $display("FAIL wrap_second: got valid %b pc4 %h instr %h want 1 00000004 %h",
               found, if_pc_plus4, if_instr2Word, bundle_of(32'h0));
    else n_pass++;
    if_id_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    do_reset();
    mem_lat     = 3;
    if_id_write = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (if_valid && imem_req && imem_addr == 32'h4 && !imem_ack) found = 1'b1;
    end
    n_checks++; if (!found) $display("FAIL rmid_setup: got %b want 1", found);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0)
      $display("FAIL rmid_async: got req %b addr %h want 0 00000000", imem_req, imem_addr);
    else n_pass++;
    n_checks++; if (if_valid !== 1'b0 || if_instr2Word !== NOP || if_pc_plus4 !== 32'h0)
      $display("FAIL rmid_outputs: got valid %b instr %h pc4 %h want 0 %h 00000000",
               if_valid, if_instr2Word, if_pc_plus4, NOP);
    else n_pass++;
    late_req++;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL rmid_first_req: got req %b addr %h want 1 00000000", imem_req, imem_addr);
    else n_pass++;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rmid_late_ack: got %b want 0", if_valid);
    else n_pass++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (if_valid) found = 1'b1;
    end
    n_checks++; if (!found || if_pc_plus4 !== 32'h4 || if_instr2Word !== bundle_of(32'h0))
      $display("FAIL rmid_bundle: got valid %b pc4 %h instr %h want 1 00000004 %h",
               found, if_pc_plus4, if_instr2Word, bundle_of(32'h0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
